netbus_async_fifo_rd_ctrl: RTL and testbench

//   Read-side controller for the NetBus dual-clock FIFO; runs entirely in the read clock domain.

---
 rtl/netbus_fifo_pkg.sv | 21 ++
 rtl/netbus_sync2.sv | 24 ++
 rtl/netbus_async_fifo_rd_ctrl.sv | 96 +++++++++
 tb/tb_netbus_async_fifo_rd_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/netbus_fifo_pkg.sv
// Shared helpers for the NetBus dual-clock FIFO: Gray conversions and synchroniser depth.
package netbus_fifo_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int PTR_MAX_W   = 32;

    // Operands are zero-extended to PTR_MAX_W; both conversions are width-independent
    // under zero extension, so callers size-cast the result back to their pointer width.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/netbus_sync2.sv
// Multi-flop bus synchroniser; input must be Gray-coded (at most one bit changing per launch).
module netbus_sync2
    import netbus_fifo_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    logic [SYNC_STAGES-1:0][W-1:0] pipe;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            pipe <= '0;
        else
            pipe <= {pipe[SYNC_STAGES-2:0], D};
    end

    assign Q = pipe[SYNC_STAGES-1];

endmodule

// File: rtl/netbus_async_fifo_rd_ctrl.sv
// Read-side controller of the NetBus dual-clock FIFO: pointer sync, RADDR issue,
// and a 2-entry first-word-fall-through output store fed from the registered RAM read.
module netbus_async_fifo_rd_ctrl
    import netbus_fifo_pkg::*;
#(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 4
) (
    input  logic                 CLKR,
    input  logic                 RST,
    input  logic [RAM_DEPTH:0]   WPTR_GRAY,
    output logic [RAM_DEPTH:0]   RPTR_GRAY,
    output logic [RAM_DEPTH-1:0] RADDR,
    input  logic [RAM_WIDTH-1:0] DOUT,
    output logic [RAM_WIDTH-1:0] RD_DATA,
    output logic                 RD_VALID,
    input  logic                 RD_READY,
    output logic                 EMPTY,
    output logic [RAM_DEPTH:0]   LEVEL
);

    localparam int PW = RAM_DEPTH + 1;

    logic [PW-1:0]        wgray_s, wbin_s, rbin, rbin_nxt;
    logic                 pending, mem_empty, issue, pop;
    logic                 head_vld, skid_vld;
    logic [RAM_WIDTH-1:0] head_data, skid_data;
    logic [1:0]           occ, occ_after_pop;

    netbus_sync2 #(.W(PW)) u_wptr_sync (
        .CLK (CLKR),
        .RST (RST),
        .D   (WPTR_GRAY),
        .Q   (wgray_s)
    );

    assign wbin_s    = PW'(gray2bin(PTR_MAX_W'(wgray_s)));
    assign mem_empty = (wbin_s == rbin);

    assign occ           = {1'b0, head_vld} + {1'b0, skid_vld};
    assign pop           = head_vld & RD_READY;
    assign occ_after_pop = occ - {1'b0, pop};
    // The in-flight word plus whatever survives this cycle's pop must leave room for one more.
    assign issue    = !mem_empty && ((occ_after_pop + {1'b0, pending}) < 2'd2);
    assign rbin_nxt = rbin + PW'(1);
    assign RADDR    = rbin[RAM_DEPTH-1:0];

    always_ff @(posedge CLKR or posedge RST) begin
        if (RST) begin
            rbin      <= '0;
            RPTR_GRAY <= '0;
            pending   <= 1'b0;
        end else begin
            pending <= issue;
            if (issue) begin
                rbin      <= rbin_nxt;
                RPTR_GRAY <= PW'(bin2gray(PTR_MAX_W'(rbin_nxt)));
            end
        end
    end

    // DOUT is only valid in the cycle after issue, so a pending word is always captured.
    always_ff @(posedge CLKR or posedge RST) begin
        if (RST) begin
            head_vld  <= 1'b0;
            head_data <= '0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
        end else if (pop) begin
            if (skid_vld) begin
                head_data <= skid_data;
                skid_vld  <= pending;
                if (pending)
                    skid_data <= DOUT;
            end else begin
                head_vld <= pending;
                if (pending)
                    head_data <= DOUT;
            end
        end else if (pending) begin
            if (!head_vld) begin
                head_vld  <= 1'b1;
                head_data <= DOUT;
            end else begin
                skid_vld  <= 1'b1;
                skid_data <= DOUT;
            end
        end
    end

    assign RD_DATA  = head_data;
    assign RD_VALID = head_vld;
    assign EMPTY    = !head_vld && mem_empty;
    assign LEVEL    = (wbin_s - rbin) + PW'(pending) + PW'(occ);

endmodule

// File: tb/tb_netbus_async_fifo_rd_ctrl.sv
// Bench: read controller paired with a FIFO memory model and a write-domain model on an unrelated clock.
module tb_netbus_async_fifo_rd_ctrl;

    logic        CLKR, CLKW, RST;
    logic [4:0]  WPTR_GRAY, RPTR_GRAY, LEVEL;
    logic [3:0]  RADDR;
    logic [15:0] DOUT, RD_DATA;
    logic        RD_VALID, RD_READY, EMPTY;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    logic [15:0] mem [16];
    logic [15:0] wr_q[$];
    logic [15:0] exp_q[$];
    logic [4:0]  wbin;

    netbus_async_fifo_rd_ctrl #(.RAM_WIDTH(16), .RAM_DEPTH(4)) dut (
        .CLKR      (CLKR),
        .RST       (RST),
        .WPTR_GRAY (WPTR_GRAY),
        .RPTR_GRAY (RPTR_GRAY),
        .RADDR     (RADDR),
        .DOUT      (DOUT),
        .RD_DATA   (RD_DATA),
        .RD_VALID  (RD_VALID),
        .RD_READY  (RD_READY),
        .EMPTY     (EMPTY),
        .LEVEL     (LEVEL)
    );

    initial begin CLKR = 0; forever #5 CLKR = ~CLKR; end
    initial begin CLKW = 0; forever #7 CLKW = ~CLKW; end

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Registered-read memory: no read enable, data one CLKR edge after address.
    always @(posedge CLKR) DOUT <= mem[RADDR];

    // Write-domain model: one word per CLKW when not full, full judged from the read pointer.
    initial begin
        wbin = 0; WPTR_GRAY = 0;
        forever begin
            @(posedge CLKW); #1;
            if (RST) begin
                wbin = 0; WPTR_GRAY = 0;
            end else if (wr_q.size() != 0 && 5'(wbin - g2b(RPTR_GRAY)) < 5'd16) begin
                mem[wbin[3:0]] = wr_q[0];
                exp_q.push_back(wr_q.pop_front());
                wbin = wbin + 5'd1;
                WPTR_GRAY = wbin ^ (wbin >> 1);
            end
        end
    end

    // Stream scoreboard: order, no duplicates, stall stability, Gray one-bit steps, LEVEL bound.
    logic [4:0]  prev_gray = 0;
    logic        prev_stall = 0;
    logic [15:0] prev_data = 0;
    always @(negedge CLKR) begin
        if (RST) begin
            prev_gray = 0; prev_stall = 0;
        end else begin
            n_checks++;
            if ($countones(prev_gray ^ RPTR_GRAY) > 1) begin
                n_fail++; $display("FAIL gray_step: %b -> %b, expected at most one bit change", prev_gray, RPTR_GRAY);
            end
            prev_gray = RPTR_GRAY;
            n_checks++;
            if (LEVEL > 5'd16) begin
                n_fail++; $display("FAIL level_bound: LEVEL=%0d, expected <= 16", LEVEL);
            end
            if (prev_stall) begin
                n_checks++;
                if (RD_VALID !== 1'b1 || RD_DATA !== prev_data) begin
                    n_fail++; $display("FAIL stall_hold: valid=%b data=%h, expected valid=1 data=%h", RD_VALID, RD_DATA, prev_data);
                end
            end
            prev_stall = RD_VALID && !RD_READY;
            prev_data  = RD_DATA;
            if (RD_VALID && RD_READY) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL pop_extra: got %h, expected no word", RD_DATA);
                end else begin
                    if (RD_DATA !== exp_q[0]) begin
                        n_fail++; $display("FAIL pop_data: got %h, expected %h", RD_DATA, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                n_pops++;
            end
        end
    end

    task automatic test_reset;
        #3;
        n_checks++;
        if (RD_VALID !== 1'b0 || EMPTY !== 1'b1 || LEVEL !== 5'd0 || RPTR_GRAY !== 5'd0 ||
            RADDR !== 4'd0 || RD_DATA !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b empty=%b level=%0d rptr=%h raddr=%h data=%h, expected 0/1/0/0/0/0",
                     RD_VALID, EMPTY, LEVEL, RPTR_GRAY, RADDR, RD_DATA);
        end
        repeat (3) @(posedge CLKR);
        #2 RST = 0;
    endtask

    task automatic test_single;
        int n = 0;
        int t = 0;
        logic [4:0] target;
        target = wbin + 5'd1;
        wr_q.push_back(16'hA5A5);
        while (wbin != target && t < 500) begin #1; t++; end
        repeat (20) begin
            @(posedge CLKR); n++; #1;
            if (RD_VALID) break;
        end
        n_checks++;
        if (n != 4) begin
            n_fail++; $display("FAIL single_latency: %0d CLKR edges, expected 4", n);
        end
        n_checks++;
        if (RD_DATA !== 16'hA5A5 || LEVEL !== 5'd1 || EMPTY !== 1'b0) begin
            n_fail++; $display("FAIL single_word: data=%h level=%0d empty=%b, expected a5a5/1/0", RD_DATA, LEVEL, EMPTY);
        end
        RD_READY = 1;
        @(posedge CLKR); #1 RD_READY = 0;
        n_checks++;
        if (EMPTY !== 1'b1 || RD_VALID !== 1'b0 || LEVEL !== 5'd0) begin
            n_fail++; $display("FAIL single_empty: empty=%b valid=%b level=%0d, expected 1/0/0", EMPTY, RD_VALID, LEVEL);
        end
    endtask

    task automatic test_burst_backpressure;
        for (int i = 0; i < 16; i++) wr_q.push_back(16'(i));
        repeat (60) @(posedge CLKR);
        #1;
        n_checks++;
        if (LEVEL !== 5'd16 || RD_VALID !== 1'b1 || RD_DATA !== 16'h0000) begin
            n_fail++; $display("FAIL burst_full: level=%0d valid=%b data=%h, expected 16/1/0000", LEVEL, RD_VALID, RD_DATA);
        end
        repeat (10) @(posedge CLKR);
        #1 RD_READY = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLKR);
            n_checks++;
            if (RD_VALID !== 1'b1 || LEVEL !== 5'(16 - i)) begin
                n_fail++; $display("FAIL burst_rate: cycle %0d valid=%b level=%0d, expected 1/%0d", i, RD_VALID, LEVEL, 16 - i);
            end
        end
        @(negedge CLKR);
        n_checks++;
        if (EMPTY !== 1'b1 || RD_VALID !== 1'b0 || LEVEL !== 5'd0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL burst_drain: empty=%b valid=%b level=%0d left=%0d, expected 1/0/0/0",
                               EMPTY, RD_VALID, LEVEL, exp_q.size());
        end
        @(posedge CLKR); #1 RD_READY = 0;
    endtask

    task automatic test_wrap_random;
        int p0 = n_pops;
        int c = 0;
        for (int i = 0; i < 40; i++) wr_q.push_back(16'($urandom));
        while (c < 3000 && (wr_q.size() != 0 || exp_q.size() != 0 || RD_VALID)) begin
            @(posedge CLKR); #1 RD_READY = 1'($urandom_range(0, 1));
            c++;
        end
        @(posedge CLKR); #1 RD_READY = 0;
        n_checks++;
        if (n_pops - p0 != 40 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL wrap_count: popped %0d left %0d, expected 40/0", n_pops - p0, exp_q.size());
        end
        n_checks++;
        if (g2b(RPTR_GRAY) !== wbin) begin
            n_fail++; $display("FAIL wrap_ptr: rptr bin=%0d, expected %0d", g2b(RPTR_GRAY), wbin);
        end
    endtask

    task automatic test_empty_idle;
        logic [3:0] ra;
        logic [4:0] rg;
        @(negedge CLKR);
        ra = RADDR; rg = RPTR_GRAY;
        repeat (10) @(posedge CLKR);
        #1;
        n_checks++;
        if (RADDR !== ra || RPTR_GRAY !== rg || EMPTY !== 1'b1 || LEVEL !== 5'd0) begin
            n_fail++; $display("FAIL empty_idle: raddr=%h rptr=%h empty=%b level=%0d, expected %h/%h/1/0",
                               RADDR, RPTR_GRAY, EMPTY, LEVEL, ra, rg);
        end
    endtask

    task automatic test_reset_mid;
        int p0;
        wr_q.push_back(16'h1111); wr_q.push_back(16'h2222); wr_q.push_back(16'h3333);
        repeat (40) @(posedge CLKR);
        #1;
        n_checks++;
        if (LEVEL !== 5'd3 || RD_VALID !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: level=%0d valid=%b, expected 3/1", LEVEL, RD_VALID);
        end
        @(negedge CLKR); #2 RST = 1;
        #1;
        n_checks++;
        if (RD_VALID !== 1'b0 || EMPTY !== 1'b1 || LEVEL !== 5'd0 || RPTR_GRAY !== 5'd0 || RADDR !== 4'd0) begin
            n_fail++; $display("FAIL rst_mid: valid=%b empty=%b level=%0d rptr=%h raddr=%h, expected 0/1/0/0/0",
                               RD_VALID, EMPTY, LEVEL, RPTR_GRAY, RADDR);
        end
        wr_q.delete(); exp_q.delete();
        repeat (5) @(posedge CLKR);
        #2 RST = 0;
        p0 = n_pops;
        wr_q.push_back(16'hBEEF);
        RD_READY = 1;
        repeat (20) @(posedge CLKR);
        #1 RD_READY = 0;
        n_checks++;
        if (n_pops - p0 != 1 || exp_q.size() != 0 || g2b(RPTR_GRAY) !== 5'd1) begin
            n_fail++; $display("FAIL rst_resume: popped %0d left %0d rptr=%0d, expected 1/0/1",
                               n_pops - p0, exp_q.size(), g2b(RPTR_GRAY));
        end
    endtask

    initial begin
        RST = 1; RD_READY = 0;
        test_reset();
        test_single();
        test_burst_backpressure();
        test_wrap_random();
        test_empty_idle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
